// File: rtl/seg7_scan_driver_pkg.sv
// Shared segment encodings for the seven-segment scan driver and its decoder.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}, MSB first.
package seg7_scan_driver_pkg;

   typedef struct packed {
      logic g;
      logic f;
      logic e;
      logic d;
      logic c;
      logic b;
      logic a;
   } seg7_t;

   localparam seg7_t SEG_0    = 7'b1000000;
   localparam seg7_t SEG_1    = 7'b1111001;
   localparam seg7_t SEG_2    = 7'b0100100;
   localparam seg7_t SEG_3    = 7'b0110000;
   localparam seg7_t SEG_4    = 7'b0011001;
   localparam seg7_t SEG_5    = 7'b0010010;
   localparam seg7_t SEG_6    = 7'b0000010;
   localparam seg7_t SEG_7    = 7'b1111000;
   localparam seg7_t SEG_8    = 7'b0000000;
   localparam seg7_t SEG_9    = 7'b0010000;
   localparam seg7_t SEG_DASH = 7'b0111111;
   localparam seg7_t SEG_OFF  = 7'h7F;

   localparam int MAX_DIGITS = 32;

   // Anodes are active-low, so "all off" is all ones; callers slice to their width.
   function automatic logic [MAX_DIGITS-1:0] anodes_off();
      return '1;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Pure combinational BCD nibble to active-low seven-segment pattern.
// Zero latency; non-decimal codes 10-15 render as a dash.
module bcd_to_seg7
   import seg7_scan_driver_pkg::*;
(
   input  logic [3:0] bcd,
   output seg7_t      seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Free-running multiplexed 7-seg driver; outputs registered one cycle behind scan state, no stall.
// Optional leading-zero blanking is built when SEG7_SCAN_LZB_EN is defined.
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [4*DIGITS-1:0]   Digits,
   output logic [6:0]            Segments,
   output logic [DIGITS-1:0]     Anodes,
   output logic                  Frame_Start
);

   localparam int SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [SW-1:0]         SLOT_LAST  = SW'(PRESCALE - 1);
   localparam logic [SW-1:0]         SLOT_BLANK = SW'(BLANK);
   localparam logic [IW-1:0]         IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [MAX_DIGITS-1:0] ALL_OFF    = anodes_off();
   localparam logic [DIGITS-1:0]     ANODES_OFF = ALL_OFF[DIGITS-1:0];

   logic [SW-1:0]       slot;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] shadow;
   logic                capture;
   logic [3:0]          cur_digit;
   seg7_t               dec_seg;
   logic [DIGITS-1:0]   lit_anodes;
   logic                suppress;

   // Capture sits on the first cycle of digit 0, which is always inside its blank window.
   assign capture     = !Reset && (slot == '0) && (idx == '0);
   assign Frame_Start = capture;

   always_comb begin
      cur_digit = 4'h0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_digit = shadow[4*k +: 4];
         end
      end
   end

   always_comb begin
      lit_anodes = ANODES_OFF;
      for (int k = 0; k < DIGITS; k++) begin
         lit_anodes[k] = (idx != IW'(k));
      end
   end

   bcd_to_seg7 u_dec (
      .bcd (cur_digit),
      .seg (dec_seg)
   );

`ifdef SEG7_SCAN_LZB_EN
   logic [DIGITS-1:0] mask;
   logic [DIGITS-1:0] mask_next;

   // A digit is blanked only if it and every more-significant digit are zero; digit 0 always shows.
   always_comb begin
      logic zeros_above;
      zeros_above = 1'b1;
      mask_next   = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zeros_above  = zeros_above && (Digits[4*k +: 4] == 4'h0);
         mask_next[k] = zeros_above;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         mask <= '0;
      end else if (capture) begin
         mask <= mask_next;
      end
   end

   always_comb begin
      suppress = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            suppress = mask[k];
         end
      end
   end
`else
   assign suppress = 1'b0;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         slot     <= '0;
         idx      <= '0;
         shadow   <= '0;
         Anodes   <= ANODES_OFF;
         Segments <= SEG_OFF;
      end else begin
         if (slot == SLOT_LAST) begin
            slot <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            slot <= slot + 1'b1;
         end

         if (capture) begin
            shadow <= Digits;
         end

         Anodes   <= (slot < SLOT_BLANK) ? ANODES_OFF : lit_anodes;
         Segments <= suppress ? SEG_OFF : dec_seg;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with DIGITS=4, PRESCALE=4, BLANK=1.
// Expected outputs come from frame-position arithmetic on the snapshot taken at each frame start.
module tb_seg7_scan_driver;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 4;
   localparam int BLANK    = 1;
   localparam int FRAME    = DIGITS * PRESCALE;

   localparam logic [6:0] SEG_TBL [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       chk;
      logic       fs;
   } exp_t;

   logic        Clock;
   logic        Reset;
   logic [15:0] Digits;
   logic [6:0]  Segments;
   logic [3:0]  Anodes;
   logic        Frame_Start;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   exp_t        sb[$];
   exp_t        pend;
   exp_t        mon_e;
   int          pos    = 0;
   logic [15:0] snap   = '0;
   bit          primed = 0;

   seg7_scan_driver #(
      .DIGITS   (DIGITS),
      .PRESCALE (PRESCALE),
      .BLANK    (BLANK)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Digits      (Digits),
      .Segments    (Segments),
      .Anodes      (Anodes),
      .Frame_Start (Frame_Start)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [6:0] exp_seg(input logic [15:0] s, input int d);
      logic [15:0] upper;
      logic [3:0]  nib;
      upper = s >> (4 * d);
      nib   = upper[3:0];
`ifdef SEG7_SCAN_LZB_EN
      if (d > 0 && upper == 16'h0) return 7'h7F;
`endif
      if (nib > 4'd9) return 7'b0111111;
      return SEG_TBL[int'(nib)];
   endfunction

   // One clock cycle: drive inputs, queue what the outputs must show this cycle,
   // then advance the reference model across the coming edge.
   task automatic step(input logic r, input logic [15:0] d);
      exp_t e;
      int   s;
      int   dig;
      Reset  = r;
      Digits = d;
      if (primed) begin
         e    = pend;
         e.fs = !r && (pos % FRAME == 0);
         sb.push_back(e);
      end
      if (r) begin
         pend = '{an: 4'hF, seg: 7'h7F, chk: 1'b1, fs: 1'b0};
         pos  = 0;
         snap = '0;
      end else begin
         s   = pos % PRESCALE;
         dig = (pos / PRESCALE) % DIGITS;
         pend.an  = (s < BLANK) ? 4'hF : ~(4'b0001 << dig);
         pend.seg = exp_seg(snap, dig);
         pend.chk = (s >= BLANK);
         pend.fs  = 1'b0;
         if (pos % FRAME == 0) snap = d;
         pos++;
      end
      @(posedge Clock);
      #1;
      primed = 1;
   endtask

   task automatic run_to(input int target, input logic [15:0] d);
      for (int i = 0; i < FRAME && (pos % FRAME) != target; i++) step(1'b0, d);
   endtask

   always @(negedge Clock) begin
      cyc++;
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         checks++;
         if (Anodes !== mon_e.an) begin
            errors++;
            $display("FAIL anodes cycle %0d: got %b expected %b", cyc, Anodes, mon_e.an);
         end
         if (mon_e.chk) begin
            checks++;
            if (Segments !== mon_e.seg) begin
               errors++;
               $display("FAIL segments cycle %0d: got %b expected %b (anodes %b)",
                        cyc, Segments, mon_e.seg, Anodes);
            end
         end
         checks++;
         if (Frame_Start !== mon_e.fs) begin
            errors++;
            $display("FAIL frame_start cycle %0d: got %b expected %b", cyc, Frame_Start, mon_e.fs);
         end
         checks++;
         if ($countones(~Anodes) > 1) begin
            errors++;
            $display("FAIL anode_overlap cycle %0d: got %b expected at most one low", cyc, Anodes);
         end
      end
   end

   initial begin
      Reset  = 1'b1;
      Digits = 16'h1234;

      repeat (3) step(1'b1, 16'h1234);
      repeat (2 * FRAME) step(1'b0, 16'h1234);

      // Mid-frame input change must not disturb the current snapshot.
      repeat (6) step(1'b0, 16'h1234);
      repeat (FRAME + 10) step(1'b0, 16'h5678);

      repeat (2 * FRAME) step(1'b0, 16'hAB90);
      repeat (2 * FRAME) step(1'b0, 16'h0005);
      repeat (2 * FRAME) step(1'b0, 16'h0000);
      repeat (FRAME) step(1'b0, 16'h0120);

      // Reset while digit 2 is at its last slot.
      run_to(11, 16'h4321);
      step(1'b1, 16'h4321);
      repeat (2 * FRAME) step(1'b0, 16'h4321);

      for (int n = 0; n < 3000; n++) begin
         logic [15:0] rd;
         logic        rr;
         rd = Digits;
         if ($urandom_range(0, 7) == 0) begin
            rd = 16'($urandom);
            rd = rd >> (4 * $urandom_range(0, 4));
         end
         rr = ($urandom_range(0, 249) == 0);
         step(rr, rd);
      end
      step(1'b0, Digits);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
